// File: rtl/csr_mtrap.sv
// Machine-mode CSR file and trap unit: CSR decode/read/write, exception and
// interrupt prioritisation, trap/MRET control and 64-bit mcycle/minstret.
module csr_mtrap #(
  parameter int XLEN        = 32,
  parameter int HART_ID     = 0,
  parameter int N_IRQ       = 4,
  parameter int VECTORED_EN = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_csr_en,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_wd,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_badaddr,
  input  logic            i_retire,
  input  logic            i_ex_illegal,
  input  logic            i_ex_inst_addr,
  input  logic            i_ex_ld_addr,
  input  logic            i_ex_st_addr,
  input  logic            i_int_msip,
  input  logic            i_int_mtip,
  input  logic            i_int_meip,
  input  logic [N_IRQ-1:0] i_int_plat,
  output logic [XLEN-1:0] o_rd,
  output logic            o_trap,
  output logic            o_eret,
  output logic [XLEN-1:0] o_tvec,
  output logic [XLEN-1:0] o_epc,
  output logic [XLEN-1:0] o_cause
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [XLEN-1:0] IRQ_MASK =
    32'h0000_0888 | (((32'h1 << N_IRQ) - 32'h1) << 16);

  logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic [2:0]      f3_s;
  logic [11:0]     addr_s, wr_sel_s;
  logic [4:0]      rs1_s, irq_code_s, plat_code_s;
  logic [XLEN-1:0] mip_s, rdata_s, operand_s, wval_s, irq_pend_s;
  logic [XLEN-1:0] exc_cause_s, exc_tval_s, cause_s, base_s;
  logic            impl_s, is_csr_s, is_sys0_s, is_ecall_s, is_ebreak_s, is_mret_s;
  logic            wr_req_s, csr_bad_s, illegal_s, exc_s, irq_any_s, trap_s;

  assign f3_s   = i_inst[14:12];
  assign addr_s = i_inst[31:20];
  assign rs1_s  = i_inst[19:15];

  // Live interrupt lines as seen through mip
  always_comb begin
    mip_s = {XLEN{1'b0}};
    mip_s[3]  = i_int_msip;
    mip_s[7]  = i_int_mtip;
    mip_s[11] = i_int_meip;
    mip_s[16 +: N_IRQ] = i_int_plat;
  end

  // CSR read mux; impl_s flags implemented addresses
  always_comb begin
    rdata_s = {XLEN{1'b0}};
    impl_s  = 1'b1;
    case (addr_s)
      A_MSTATUS:   rdata_s = {19'd0, 2'b11, 3'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};
      A_MISA:      rdata_s = 32'h4000_1100;
      A_MIE:       rdata_s = mie_q;
      A_MTVEC:     rdata_s = mtvec_q;
      A_MSCRATCH:  rdata_s = mscratch_q;
      A_MEPC:      rdata_s = mepc_q;
      A_MCAUSE:    rdata_s = mcause_q;
      A_MTVAL:     rdata_s = mtval_q;
      A_MIP:       rdata_s = mip_s;
      A_MCYCLE:    rdata_s = mcycle_q[31:0];
      A_MCYCLEH:   rdata_s = mcycle_q[63:32];
      A_MINSTRET:  rdata_s = minstret_q[31:0];
      A_MINSTRETH: rdata_s = minstret_q[63:32];
      A_MHARTID:   rdata_s = 32'(HART_ID);
      default:     impl_s  = 1'b0;
    endcase
  end

  // Instruction decode, write value and illegal detection
  always_comb begin
    is_csr_s    = i_csr_en && (f3_s != 3'b000);
    is_sys0_s   = i_csr_en && (f3_s == 3'b000);
    is_ecall_s  = is_sys0_s && (addr_s == 12'h000);
    is_ebreak_s = is_sys0_s && (addr_s == 12'h001);
    is_mret_s   = is_sys0_s && (addr_s == 12'h302);
    wr_req_s    = is_csr_s && ((f3_s[1:0] == 2'b01) || (rs1_s != 5'd0));
    operand_s   = f3_s[2] ? {27'd0, rs1_s} : i_wd;
    case (f3_s[1:0])
      2'b01:   wval_s = operand_s;
      2'b10:   wval_s = rdata_s | operand_s;
      2'b11:   wval_s = rdata_s & ~operand_s;
      default: wval_s = rdata_s;
    endcase
    // misa is treated as read-only even though its address is in the RW range
    csr_bad_s = is_csr_s && (!impl_s || (f3_s[1:0] == 2'b00) ||
                (wr_req_s && ((addr_s[11:10] == 2'b11) || (addr_s == A_MISA))));
    illegal_s = i_ex_illegal || csr_bad_s ||
                (is_sys0_s && !(is_ecall_s || is_ebreak_s || is_mret_s));
  end

  // Exception and interrupt prioritisation
  always_comb begin
    exc_s = 1'b1;
    if (i_ex_inst_addr) begin
      exc_cause_s = 32'd0;  exc_tval_s = i_badaddr;
    end else if (illegal_s) begin
      exc_cause_s = 32'd2;  exc_tval_s = i_inst;
    end else if (is_ebreak_s) begin
      exc_cause_s = 32'd3;  exc_tval_s = i_pc;
    end else if (is_ecall_s) begin
      exc_cause_s = 32'd11; exc_tval_s = 32'd0;
    end else if (i_ex_ld_addr) begin
      exc_cause_s = 32'd4;  exc_tval_s = i_badaddr;
    end else if (i_ex_st_addr) begin
      exc_cause_s = 32'd6;  exc_tval_s = i_badaddr;
    end else begin
      exc_s = 1'b0; exc_cause_s = 32'd0; exc_tval_s = 32'd0;
    end
    irq_pend_s  = {XLEN{mst_mie_q}} & mie_q & mip_s;
    plat_code_s = 5'd0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      plat_code_s = irq_pend_s[16 + k] ? 5'(16 + k) : plat_code_s;
    end
    irq_any_s = |irq_pend_s;
    if (irq_pend_s[11])     irq_code_s = 5'd11;
    else if (irq_pend_s[3]) irq_code_s = 5'd3;
    else if (irq_pend_s[7]) irq_code_s = 5'd7;
    else                    irq_code_s = plat_code_s;
    trap_s  = i_rst && (exc_s || irq_any_s);
    cause_s = exc_s ? exc_cause_s : {1'b1, 26'd0, irq_code_s};
    base_s  = {mtvec_q[XLEN-1:2], 2'b00};
  end

  assign o_trap  = trap_s;
  assign o_eret  = i_rst && is_mret_s && !trap_s;
  assign o_cause = cause_s;
  assign o_epc   = mepc_q;
  assign o_rd    = rdata_s;
  assign o_tvec  = ((mtvec_q[1:0] == 2'b01) && !exc_s && irq_any_s) ?
                   base_s + {25'd0, irq_code_s, 2'b00} : base_s;
  assign wr_sel_s = (wr_req_s && !trap_s) ? addr_s : 12'h000;

  // Next architectural state: trap commit, MRET, then CSR write
  always_comb begin
    mst_mie_d  = mst_mie_q;  mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;      mtvec_d    = mtvec_q;    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;     mcause_d   = mcause_q;   mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = (i_retire && !trap_s) ? minstret_q + 64'd1 : minstret_q;
    if (trap_s) begin
      mepc_d     = {i_pc[XLEN-1:2], 2'b00};
      mcause_d   = cause_s;
      mtval_d    = exc_s ? exc_tval_s : 32'd0;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (o_eret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else begin
      case (wr_sel_s)
        A_MSTATUS:   begin mst_mie_d = wval_s[3]; mst_mpie_d = wval_s[7]; end
        A_MIE:       mie_d      = wval_s & IRQ_MASK;
        A_MTVEC:     mtvec_d    = {wval_s[XLEN-1:2],
                                   ((wval_s[1:0] == 2'b01) && (VECTORED_EN != 0)) ? 2'b01 : 2'b00};
        A_MSCRATCH:  mscratch_d = wval_s;
        A_MEPC:      mepc_d     = {wval_s[XLEN-1:2], 2'b00};
        A_MCAUSE:    mcause_d   = wval_s;
        A_MTVAL:     mtval_d    = wval_s;
        A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wval_s};
        A_MCYCLEH:   mcycle_d   = {wval_s, mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], wval_s};
        A_MINSTRETH: minstret_d = {wval_s, minstret_q[31:0]};
        default:     mcause_d   = mcause_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      mst_mie_q  <= 1'b0;      mst_mpie_q <= 1'b0;
      mie_q      <= 32'd0;     mtvec_q    <= 32'd0;   mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;     mcause_q   <= 32'd0;   mtval_q    <= 32'd0;
      mcycle_q   <= 64'd0;     minstret_q <= 64'd0;
    end else begin
      mst_mie_q  <= mst_mie_d; mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;     mtvec_q    <= mtvec_d; mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;    mcause_q   <= mcause_d; mtval_q   <= mtval_d;
      mcycle_q   <= mcycle_d;  minstret_q <= minstret_d;
    end
  end

endmodule
